tx_iq_playback_ctrl: RTL and testbench



---
 rtl/tx_iq_playback_pkg.sv | 22 ++
 rtl/tx_iq_playback_ram.sv | 24 ++
 rtl/tx_iq_playback_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_tx_iq_playback_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/tx_iq_playback_pkg.sv
// rtl/tx_iq_playback_pkg.sv - shared types and constants for the IQ playback sequencer
package tx_iq_playback_pkg;

  localparam int IQ_DATA_WIDTH_DEF  = 16;
  localparam int BUF_ADDR_WIDTH_DEF = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Saturation limits for a signed component of width w
  function automatic longint sat_hi(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint sat_lo(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/tx_iq_playback_ram.sv
// rtl/tx_iq_playback_ram.sv - simple dual-port sample buffer with registered read
module tx_iq_playback_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH) - 1];

  // One write port, one registered read port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/tx_iq_playback_ctrl.sv
// rtl/tx_iq_playback_ctrl.sv - IQ capture buffer and triggered replay sequencer (option: TX_IQ_PLAYBACK_GAIN_EN)
module tx_iq_playback_ctrl
  import tx_iq_playback_pkg::*;
#(
  parameter int IQ_DATA_WIDTH  = IQ_DATA_WIDTH_DEF,
  parameter int BUF_ADDR_WIDTH = BUF_ADDR_WIDTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [2*IQ_DATA_WIDTH-1:0] wr_data,
  input  logic                       buf_clr,
  input  logic                       trigger,
  input  logic                       abort,
  input  logic [7:0]                 repeat_num,
  input  logic [15:0]                gap_len,
  input  logic [9:0]                 play_gain,
  output logic [2*IQ_DATA_WIDTH-1:0] iq_out,
  output logic                       iq_valid,
  input  logic                       iq_ready,
  output logic [BUF_ADDR_WIDTH:0]    buf_count,
  output logic                       busy,
  output logic                       done,
  output logic                       wr_err
);

  localparam int AW = BUF_ADDR_WIDTH;
  localparam int W  = IQ_DATA_WIDTH;

  state_t          state, state_n;
  logic [AW-1:0]   rd_ptr, rd_ptr_n, last_idx;
  logic [7:0]      rep_cnt, rep_cnt_n, repeat_q;
  logic [15:0]     gap_cnt, gap_cnt_n, gap_q;
  logic            valid_n, done_n, load_cfg, trig_d;
  logic [2*W-1:0]  rdata;
  logic            trig_edge, wr_accept;

  assign trig_edge = trigger & ~trig_d;
  assign wr_accept = wr_en & ~buf_clr & (state == IDLE) & ~buf_count[AW];
  assign busy      = (state == PLAY) || (state == GAP);

  tx_iq_playback_ram #(
    .DATA_WIDTH(2 * W),
    .ADDR_WIDTH(AW)
  ) u_ram (
    .clk  (clk),
    .we   (wr_accept),
    .waddr(buf_count[AW-1:0]),
    .wdata(wr_data),
    .raddr(rd_ptr_n),
    .rdata(rdata)
  );

  // Capture side: write pointer doubles as sample count; wr_err is sticky until cleared
  always_ff @(posedge clk) begin
    if (rst || buf_clr) begin
      buf_count <= '0;
      wr_err    <= 1'b0;
    end else if (wr_accept) begin
      buf_count <= buf_count + 1'b1;
    end else if (wr_en) begin
      wr_err <= 1'b1;
    end
  end

  // Sequencer state, handshake and replay configuration registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rd_ptr   <= '0;
      rep_cnt  <= '0;
      gap_cnt  <= '0;
      iq_valid <= 1'b0;
      done     <= 1'b0;
      trig_d   <= 1'b0;
      repeat_q <= '0;
      gap_q    <= '0;
      last_idx <= '0;
    end else begin
      state    <= state_n;
      rd_ptr   <= rd_ptr_n;
      rep_cnt  <= rep_cnt_n;
      gap_cnt  <= gap_cnt_n;
      iq_valid <= valid_n;
      done     <= done_n;
      trig_d   <= trigger;
      if (load_cfg) begin
        repeat_q <= repeat_num;
        gap_q    <= gap_len;
        last_idx <= AW'(buf_count - 1'b1);
      end
    end
  end

  // Next state; rd_ptr_n is also the RAM read address so a held sample stays put
  always_comb begin
    state_n   = state;
    rd_ptr_n  = rd_ptr;
    rep_cnt_n = rep_cnt;
    gap_cnt_n = gap_cnt;
    valid_n   = 1'b0;
    done_n    = 1'b0;
    load_cfg  = 1'b0;
    if (abort) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (trig_edge && buf_count != '0) begin
            state_n   = PLAY;
            rd_ptr_n  = '0;
            rep_cnt_n = '0;
            load_cfg  = 1'b1;
          end
        end
        PLAY: begin
          valid_n = 1'b1;
          if (iq_valid && iq_ready) begin
            if (rd_ptr == last_idx) begin
              rd_ptr_n  = '0;
              rep_cnt_n = 8'(rep_cnt + 1'b1);
              if (repeat_q != 8'd0 && rep_cnt_n == repeat_q) begin
                state_n = IDLE;
                valid_n = 1'b0;
                done_n  = 1'b1;
              end else if (gap_q != 16'd0) begin
                state_n   = GAP;
                valid_n   = 1'b0;
                gap_cnt_n = '0;
              end
            end else begin
              rd_ptr_n = rd_ptr + 1'b1;
            end
          end
        end
        GAP: begin
          // buf[0] is read during the last gap cycle so valid rises right after it
          if (gap_cnt == gap_q - 16'd1) begin
            state_n = PLAY;
            valid_n = 1'b1;
          end else begin
            gap_cnt_n = gap_cnt + 16'd1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

`ifdef TX_IQ_PLAYBACK_GAIN_EN
  localparam int PW = W + 10;
  localparam logic signed [PW-1:0] SAT_HI = PW'(sat_hi(W));
  localparam logic signed [PW-1:0] SAT_LO = PW'(sat_lo(W));

  function automatic logic [W-1:0] scale(input logic [W-1:0] x, input logic [9:0] g);
    logic signed [PW-1:0] xe, ge, p;
    xe = PW'($signed(x));
    ge = PW'($signed(g));
    p  = (xe * ge) >>> 7;
    if (p > SAT_HI) begin
      scale = SAT_HI[W-1:0];
    end else if (p < SAT_LO) begin
      scale = SAT_LO[W-1:0];
    end else begin
      scale = p[W-1:0];
    end
  endfunction

  // Gain applied ahead of the output so latency matches the plain build
  always_comb begin
    iq_out = '0;
    if (iq_valid) begin
      iq_out = {scale(rdata[2*W-1:W], play_gain), scale(rdata[W-1:0], play_gain)};
    end
  end
`else
  logic play_gain_unused;
  assign play_gain_unused = ^play_gain;

  // Samples pass straight through; output forced to zero when not valid
  always_comb begin
    iq_out = '0;
    if (iq_valid) begin
      iq_out = rdata;
    end
  end
`endif

endmodule

// File: tb/tb_tx_iq_playback_ctrl.sv
// tb/tb_tx_iq_playback_ctrl.sv - directed table-driven bench for tx_iq_playback_ctrl
module tb_tx_iq_playback_ctrl;

  logic        clk = 1'b0;
  logic        rst, wr_en, buf_clr, trigger, abort, iq_ready;
  logic [31:0] wr_data;
  logic [7:0]  repeat_num;
  logic [15:0] gap_len;
  logic [9:0]  play_gain;
  logic [31:0] iq_out;
  logic        iq_valid, busy, done, wr_err;
  logic [9:0]  buf_count;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        ready;
    logic        valid;
    logic [31:0] out;
    logic        done;
    logic        busy;
  } vec_t;

  vec_t vec [0:47];

  tx_iq_playback_ctrl dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .buf_clr(buf_clr),
    .trigger(trigger), .abort(abort), .repeat_num(repeat_num), .gap_len(gap_len),
    .play_gain(play_gain), .iq_out(iq_out), .iq_valid(iq_valid), .iq_ready(iq_ready),
    .buf_count(buf_count), .busy(busy), .done(done), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] samp(input int k);
    return {16'(k + 1), 16'(k + 1)};
  endfunction

  function automatic vec_t mk(input logic r, input logic v, input logic [31:0] o,
                              input logic d, input logic b);
    vec_t t;
    t.ready = r; t.valid = v; t.out = o; t.done = d; t.busy = b;
    return t;
  endfunction

  task automatic write_one(input logic [31:0] d);
    wr_en = 1'b1; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic pulse_trigger();
    trigger = 1'b1;
    step();
    trigger = 1'b0;
  endtask

  task automatic run_table(input string tag, input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      iq_ready = vec[i].ready;
      chk($sformatf("%s[%0d].valid", tag, i - lo), {31'd0, iq_valid}, {31'd0, vec[i].valid});
      chk($sformatf("%s[%0d].out", tag, i - lo), iq_out, vec[i].out);
      chk($sformatf("%s[%0d].done", tag, i - lo), {31'd0, done}, {31'd0, vec[i].done});
      chk($sformatf("%s[%0d].busy", tag, i - lo), {31'd0, busy}, {31'd0, vec[i].busy});
      step();
    end
    iq_ready = 1'b1;
  endtask

  initial begin
    // Section A [0:11): repeat 2, no gap
    vec[0] = mk(1, 0, 32'h0, 0, 1);
    for (int k = 0; k < 8; k++) vec[1 + k] = mk(1, 1, samp(k % 4), 0, 1);
    vec[9]  = mk(1, 0, 32'h0, 1, 0);
    vec[10] = mk(1, 0, 32'h0, 0, 0);
    // Section B [11:25): repeat 2, gap 3
    vec[11] = mk(1, 0, 32'h0, 0, 1);
    for (int k = 0; k < 4; k++) vec[12 + k] = mk(1, 1, samp(k), 0, 1);
    for (int k = 0; k < 3; k++) vec[16 + k] = mk(1, 0, 32'h0, 0, 1);
    for (int k = 0; k < 4; k++) vec[19 + k] = mk(1, 1, samp(k), 0, 1);
    vec[23] = mk(1, 0, 32'h0, 1, 0);
    vec[24] = mk(1, 0, 32'h0, 0, 0);
    // Section C [25:33): repeat 1, ready 1,0,0,1 on the second sample
    vec[25] = mk(1, 0, 32'h0, 0, 1);
    vec[26] = mk(1, 1, samp(0), 0, 1);
    vec[27] = mk(0, 1, samp(1), 0, 1);
    vec[28] = mk(0, 1, samp(1), 0, 1);
    vec[29] = mk(1, 1, samp(1), 0, 1);
    vec[30] = mk(1, 1, samp(2), 0, 1);
    vec[31] = mk(1, 1, samp(3), 0, 1);
    vec[32] = mk(1, 0, 32'h0, 1, 0);

    rst = 1'b1; wr_en = 1'b0; wr_data = '0; buf_clr = 1'b0; trigger = 1'b0;
    abort = 1'b0; iq_ready = 1'b1; repeat_num = 8'd0; gap_len = 16'd0;
`ifdef TX_IQ_PLAYBACK_GAIN_EN
    play_gain = 10'd128;
`else
    play_gain = 10'd3;
`endif
    step(); step();
    rst = 1'b0;
    chk("rst.valid", {31'd0, iq_valid}, 32'd0);
    chk("rst.out", iq_out, 32'd0);
    chk("rst.count", {22'd0, buf_count}, 32'd0);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.done", {31'd0, done}, 32'd0);
    chk("rst.wr_err", {31'd0, wr_err}, 32'd0);

    // buf_clr wins over a same-cycle write
    write_one(32'hdead_beef);
    chk("wr1.count", {22'd0, buf_count}, 32'd1);
    buf_clr = 1'b1; wr_en = 1'b1; step(); buf_clr = 1'b0; wr_en = 1'b0;
    chk("clrwr.count", {22'd0, buf_count}, 32'd0);
    chk("clrwr.wr_err", {31'd0, wr_err}, 32'd0);

    // Fill to depth, then one more
    wr_en = 1'b1;
    for (int i = 0; i < 512; i++) begin
      wr_data = i;
      step();
    end
    chk("full.count", {22'd0, buf_count}, 32'd512);
    chk("full.wr_err", {31'd0, wr_err}, 32'd0);
    step();
    wr_en = 1'b0;
    chk("ovf.count", {22'd0, buf_count}, 32'd512);
    chk("ovf.wr_err", {31'd0, wr_err}, 32'd1);
    buf_clr = 1'b1; step(); buf_clr = 1'b0;
    chk("clr.count", {22'd0, buf_count}, 32'd0);
    chk("clr.wr_err", {31'd0, wr_err}, 32'd0);

    // Trigger on an empty buffer is ignored
    pulse_trigger(); step();
    chk("empty_trig.busy", {31'd0, busy}, 32'd0);
    chk("empty_trig.valid", {31'd0, iq_valid}, 32'd0);

    for (int k = 0; k < 4; k++) write_one(samp(k));
    chk("load.count", {22'd0, buf_count}, 32'd4);

    // Section A; registers changed mid-replay must not matter
    repeat_num = 8'd2; gap_len = 16'd0;
    pulse_trigger();
    repeat_num = 8'd7; gap_len = 16'd9;
    run_table("A", 0, 11);

    repeat_num = 8'd2; gap_len = 16'd3;
    pulse_trigger();
    run_table("B", 11, 25);

    repeat_num = 8'd1; gap_len = 16'd0;
    pulse_trigger();
    run_table("C", 25, 33);

    // Infinite replay, dropped write while busy, abort, retrigger
    repeat_num = 8'd0; gap_len = 16'd0;
    pulse_trigger(); step();
    chk("inf.first", iq_out, samp(0));
    write_one(32'h1234_5678);
    chk("busy_wr.wr_err", {31'd0, wr_err}, 32'd1);
    chk("busy_wr.count", {22'd0, buf_count}, 32'd4);
    for (int i = 0; i < 96; i++) step();
    chk("inf.valid", {31'd0, iq_valid}, 32'd1);
    chk("inf.busy", {31'd0, busy}, 32'd1);
    abort = 1'b1; step(); abort = 1'b0;
    chk("abort.busy", {31'd0, busy}, 32'd0);
    chk("abort.valid", {31'd0, iq_valid}, 32'd0);
    chk("abort.out", iq_out, 32'd0);
    chk("abort.done", {31'd0, done}, 32'd0);
    step();
    chk("abort.done2", {31'd0, done}, 32'd0);
    chk("abort.count", {22'd0, buf_count}, 32'd4);
    pulse_trigger(); step();
    chk("retrig.valid", {31'd0, iq_valid}, 32'd1);
    chk("retrig.out0", iq_out, samp(0));
    step();
    chk("retrig.out1", iq_out, samp(1));
    abort = 1'b1; step(); abort = 1'b0;
    buf_clr = 1'b1; step(); buf_clr = 1'b0;
    chk("final_clr.wr_err", {31'd0, wr_err}, 32'd0);
    chk("final_clr.count", {22'd0, buf_count}, 32'd0);

`ifdef TX_IQ_PLAYBACK_GAIN_EN
    write_one(32'h0000_4000);
    write_one(32'h0000_0100);
    repeat_num = 8'd1; iq_ready = 1'b0; play_gain = 10'd256;
    pulse_trigger(); step();
    chk("gain.sat", iq_out, 32'h0000_7fff);
    play_gain = 10'h380;
    iq_ready = 1'b1;
    step();
    chk("gain.neg", iq_out, 32'h0000_ff00);
    step();
    chk("gain.done", {31'd0, done}, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
